// File: rtl/rd53_pkg.sv
// Shared definitions for the rd53 serial checker family.
package rd53_pkg;

  localparam int DATA_W_DEF = 5;
  localparam int CNT_W_DEF  = 3;

  typedef enum logic [1:0] {
    ST_RECV = 2'd0,
    ST_PAR  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

  // Ceiling log2 with a fixed-bound loop so it elaborates as a constant.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((longint'(1) << i) < longint'(value)) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/rd53_weight_acc.sv
// Serial ones-counter: adds one incoming bit per enabled cycle.
module rd53_weight_acc
  import rd53_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  // Clear wins over enable so an abort never leaks a stray count.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, bit_in};
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/rd53_serial_checker.sv
// Bit-serial rd53 receiver: deserialises DATA_W bits, counts ones and
// checks the trailing parity bit against the weight LSB.
module rd53_serial_checker
  import rd53_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int CNT_W      = CNT_W_DEF,
  parameter int ODD_PARITY = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              sync_clr,
  input  logic              s_valid,
  input  logic              s_bit,
  output logic              s_ready,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic [CNT_W-1:0]  m_weight,
  output logic              m_par_err
);

  localparam int IDX_W = (clog2(DATA_W) < 1) ? 1 : clog2(DATA_W);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);
  localparam logic ODD_BIT = (ODD_PARITY != 0);

  // A weight field too narrow or too wide for the word is a configuration bug.
  generate
    if (CNT_W != clog2(DATA_W + 1)) begin : g_cnt_w_check
      $error("rd53_serial_checker: CNT_W must equal clog2(DATA_W+1)");
    end
  endgenerate

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [DATA_W-1:0]  shreg_q, shreg_d;
  logic [DATA_W-1:0]  m_data_q, m_data_d;
  logic [CNT_W-1:0]   m_weight_q, m_weight_d;
  logic               m_par_err_q, m_par_err_d;
  logic               m_valid_q, m_valid_d;

  logic               accept;
  logic               acc_clr;
  logic               acc_en;
  logic [CNT_W-1:0]   acc;

  assign s_ready = (state_q != ST_HOLD);
  assign accept  = s_valid && s_ready;

  rd53_weight_acc #(
    .CNT_W (CNT_W)
  ) u_weight_acc (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (acc_clr),
    .en     (acc_en),
    .bit_in (s_bit),
    .count  (acc)
  );

  // Next-state, shift-register and result logic; sync_clr overrides all.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    shreg_d     = shreg_q;
    m_data_d    = m_data_q;
    m_weight_d  = m_weight_q;
    m_par_err_d = m_par_err_q;
    m_valid_d   = m_valid_q;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;

    unique case (state_q)
      ST_RECV: begin
        if (accept) begin
          for (int i = 0; i < DATA_W; i++) begin
            if (idx_q == IDX_W'(i)) begin
              shreg_d[i] = s_bit;
            end
          end
          acc_en = 1'b1;
          if (idx_q == IDX_LAST) begin
            state_d = ST_PAR;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      ST_PAR: begin
        if (accept) begin
          m_data_d    = shreg_q;
          m_weight_d  = acc;
          m_par_err_d = s_bit ^ acc[0] ^ ODD_BIT;
          m_valid_d   = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (m_valid_q && m_ready) begin
          m_valid_d = 1'b0;
          state_d   = ST_RECV;
          idx_d     = '0;
          acc_clr   = 1'b1;
        end
      end
      default: begin
        state_d = ST_RECV;
        idx_d   = '0;
        acc_clr = 1'b1;
      end
    endcase

    // Abort: drop any partial or held word; result fields keep stale values.
    if (sync_clr) begin
      state_d     = ST_RECV;
      idx_d       = '0;
      shreg_d     = shreg_q;
      m_data_d    = m_data_q;
      m_weight_d  = m_weight_q;
      m_par_err_d = m_par_err_q;
      m_valid_d   = 1'b0;
      acc_clr     = 1'b1;
      acc_en      = 1'b0;
    end
  end

  // State, index, shift register and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_RECV;
      idx_q       <= '0;
      shreg_q     <= '0;
      m_data_q    <= '0;
      m_weight_q  <= '0;
      m_par_err_q <= 1'b0;
      m_valid_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      shreg_q     <= shreg_d;
      m_data_q    <= m_data_d;
      m_weight_q  <= m_weight_d;
      m_par_err_q <= m_par_err_d;
      m_valid_q   <= m_valid_d;
    end
  end

  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_weight  = m_weight_q;
  assign m_par_err = m_par_err_q;

endmodule

// File: tb/tb_rd53_serial_checker.sv
// Directed bench for rd53_serial_checker: even- and odd-parity instances
// share one stimulus stream and are checked against a word-level model.
module tb_rd53_serial_checker;

  localparam int DW = 5;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          sync_clr = 1'b0;
  logic          s_valid = 1'b0;
  logic          s_bit = 1'b0;
  logic          m_ready = 1'b0;

  logic          s_ready_e, m_valid_e, m_par_err_e;
  logic [DW-1:0] m_data_e;
  logic [CW-1:0] m_weight_e;
  logic          s_ready_o, m_valid_o, m_par_err_o;
  logic [DW-1:0] m_data_o;
  logic [CW-1:0] m_weight_o;

  int n_checks = 0;
  int n_err = 0;

  // Model state: bits accepted so far and the word currently presented.
  bit            bits[$];
  bit            holding = 1'b0;
  logic [DW-1:0] exp_data = '0;
  int            exp_wt = 0;
  bit            exp_err = 1'b0;

  always #5 clk = ~clk;

  rd53_serial_checker #(.DATA_W(DW), .CNT_W(CW), .ODD_PARITY(0)) dut_even (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .s_valid(s_valid), .s_bit(s_bit),
    .s_ready(s_ready_e), .m_valid(m_valid_e), .m_ready(m_ready), .m_data(m_data_e),
    .m_weight(m_weight_e), .m_par_err(m_par_err_e)
  );

  rd53_serial_checker #(.DATA_W(DW), .CNT_W(CW), .ODD_PARITY(1)) dut_odd (
    .clk(clk), .rst_n(rst_n), .sync_clr(sync_clr), .s_valid(s_valid), .s_bit(s_bit),
    .s_ready(s_ready_o), .m_valid(m_valid_o), .m_ready(m_ready), .m_data(m_data_o),
    .m_weight(m_weight_o), .m_par_err(m_par_err_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Word-level model: collect accepted bits, evaluate once DW+1 have arrived.
  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        bits.delete();
        holding = 1'b0;
      end else if (sync_clr) begin
        bits.delete();
        holding = 1'b0;
      end else if (holding) begin
        if (m_ready) holding = 1'b0;
      end else if (s_valid) begin
        bits.push_back(s_bit);
        if (bits.size() == DW + 1) begin
          exp_wt = 0;
          for (int i = 0; i < DW; i++) begin
            exp_data[i] = bits[i];
            exp_wt += int'(bits[i]);
          end
          exp_err = bits[DW] ^ exp_wt[0];
          holding = 1'b1;
          bits.delete();
        end
      end
    end
  end

  // Per-cycle comparison of both instances against the model.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_m_valid_e", {31'd0, m_valid_e}, 32'd0);
        chk("rst_m_valid_o", {31'd0, m_valid_o}, 32'd0);
        chk("rst_m_data_e", {27'd0, m_data_e}, 32'd0);
        chk("rst_m_weight_e", {29'd0, m_weight_e}, 32'd0);
        chk("rst_m_par_err_e", {31'd0, m_par_err_e}, 32'd0);
      end else begin
        chk("s_ready_e", {31'd0, s_ready_e}, {31'd0, !holding});
        chk("s_ready_o", {31'd0, s_ready_o}, {31'd0, !holding});
        chk("m_valid_e", {31'd0, m_valid_e}, {31'd0, holding});
        chk("m_valid_o", {31'd0, m_valid_o}, {31'd0, holding});
        if (holding) begin
          chk("m_data_e", {27'd0, m_data_e}, {27'd0, exp_data});
          chk("m_data_o", {27'd0, m_data_o}, {27'd0, exp_data});
          chk("m_weight_e", {29'd0, m_weight_e}, 32'(exp_wt));
          chk("m_weight_o", {29'd0, m_weight_o}, 32'(exp_wt));
          chk("m_par_err_e", {31'd0, m_par_err_e}, {31'd0, exp_err});
          chk("m_par_err_o", {31'd0, m_par_err_o}, {31'd0, ~exp_err});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    int n;
    n = 0;
    s_valid = 1'b1;
    s_bit = b;
    while (!s_ready_e && n < 50) begin
      cyc();
      n++;
    end
    if (n >= 50) chk("send_bit_timeout", 32'(n), 32'd0);
    cyc();
    s_valid = 1'b0;
  endtask

  task automatic send_data(input logic [DW-1:0] d);
    for (int i = 0; i < DW; i++) send_bit(d[i]);
  endtask

  task automatic send_word(input logic [DW-1:0] d, input logic par);
    send_data(d);
    chk("pre_par_m_valid", {31'd0, m_valid_e}, 32'd0);
    send_bit(par);
  endtask

  task automatic consume();
    m_ready = 1'b1;
    cyc();
    m_ready = 1'b0;
    chk("consume_m_valid", {31'd0, m_valid_e}, 32'd0);
  endtask

  task automatic lit(input string tag, input logic [DW-1:0] d, input int w,
                     input logic err_even);
    chk({tag, "_valid"}, {31'd0, m_valid_e}, 32'd1);
    chk({tag, "_data"}, {27'd0, m_data_e}, {27'd0, d});
    chk({tag, "_weight"}, {29'd0, m_weight_e}, 32'(w));
    chk({tag, "_err_even"}, {31'd0, m_par_err_e}, {31'd0, err_even});
    chk({tag, "_err_odd"}, {31'd0, m_par_err_o}, {31'd0, ~err_even});
  endtask

  initial begin
    int cnt;
    int k;
    logic [DW-1:0] d_snap;
    logic [CW-1:0] w_snap;
    logic          e_snap;

    // Reset
    #2 rst_n = 1'b0;
    #1;
    chk("reset_m_valid", {31'd0, m_valid_e}, 32'd0);
    chk("reset_m_data", {27'd0, m_data_e}, 32'd0);
    #20 rst_n = 1'b1;
    cyc();
    chk("reset_s_ready", {31'd0, s_ready_e}, 32'd1);
    $display("txn reset done");

    // Word 1: x0..x4 = 1,0,1,1,0 parity 1
    send_word(5'b01101, 1'b1);
    lit("t1", 5'b01101, 3, 1'b0);
    $display("txn t1 data=%b weight=%0d err=%0d", m_data_e, m_weight_e, m_par_err_e);
    consume();

    // Word 2: all ones, parity 0 -> even error, odd ok
    send_word(5'b11111, 1'b0);
    lit("t2", 5'b11111, 5, 1'b1);
    $display("txn t2 data=%b weight=%0d err_even=%0d err_odd=%0d",
             m_data_e, m_weight_e, m_par_err_e, m_par_err_o);
    consume();

    // Word 3: all zero with s_valid toggling each cycle
    cnt = 0;
    k = 0;
    while (m_valid_e !== 1'b1 && cnt < 40) begin
      chk("t3_s_ready", {31'd0, s_ready_e}, 32'd1);
      s_valid = (cnt % 2 == 0) && (k < DW + 1);
      s_bit = 1'b0;
      if (s_valid && s_ready_e) k++;
      cyc();
      cnt++;
    end
    s_valid = 1'b0;
    chk("t3_cycles", 32'(cnt + 1), 32'd12);
    lit("t3", 5'b00000, 0, 1'b0);
    $display("txn t3 cycles=%0d weight=%0d err=%0d", cnt + 1, m_weight_e, m_par_err_e);

    // Back-pressure: hold m_ready low for 4 cycles
    d_snap = m_data_e;
    w_snap = m_weight_e;
    e_snap = m_par_err_e;
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("t4_s_ready_low", {31'd0, s_ready_e}, 32'd0);
      chk("t4_valid_held", {31'd0, m_valid_e}, 32'd1);
      chk("t4_data_stable", {27'd0, m_data_e}, {27'd0, d_snap});
      chk("t4_weight_stable", {29'd0, m_weight_e}, {29'd0, w_snap});
      chk("t4_err_stable", {31'd0, m_par_err_e}, {31'd0, e_snap});
    end
    consume();
    send_word(5'b00001, 1'b1);
    lit("t4", 5'b00001, 1, 1'b0);
    $display("txn t4 data=%b weight=%0d err=%0d", m_data_e, m_weight_e, m_par_err_e);
    consume();

    // sync_clr after 3 bits, with a bit offered in the same cycle
    send_bit(1'b1);
    send_bit(1'b1);
    send_bit(1'b1);
    sync_clr = 1'b1;
    s_valid = 1'b1;
    s_bit = 1'b1;
    cyc();
    sync_clr = 1'b0;
    s_valid = 1'b0;
    chk("t5_after_clr_valid", {31'd0, m_valid_e}, 32'd0);
    send_word(5'b10010, 1'b0);
    lit("t5", 5'b10010, 2, 1'b0);
    $display("txn t5 data=%b weight=%0d err=%0d", m_data_e, m_weight_e, m_par_err_e);
    consume();

    // Asynchronous reset while waiting for the parity bit
    send_data(5'b10101);
    #3 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", {31'd0, m_valid_e}, 32'd0);
    chk("t6_rst_data", {27'd0, m_data_e}, 32'd0);
    chk("t6_rst_weight", {29'd0, m_weight_e}, 32'd0);
    cyc();
    cyc();
    #2 rst_n = 1'b1;
    cyc();
    chk("t6_s_ready", {31'd0, s_ready_e}, 32'd1);
    send_word(5'b00011, 1'b0);
    lit("t6", 5'b00011, 2, 1'b0);
    $display("txn t6 data=%b weight=%0d err=%0d", m_data_e, m_weight_e, m_par_err_e);
    consume();

    cyc();
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
